// File: rtl/alu_exec_unit.sv
// 32-bit execution unit for the {Sign, ALUCtrl} control word: single-cycle logic/arith ops,
// iterative one-bit-per-cycle shifts, valid/ready request and response channels.
module alu_exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        Sign,
    input  logic [4:0]  ALUCtrl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        illegal
);

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4;
    localparam logic [4:0] OP_NOR = 5'd5;
    localparam logic [4:0] OP_SLL = 5'd6;
    localparam logic [4:0] OP_SRL = 5'd7;
    localparam logic [4:0] OP_SRA = 5'd8;
    localparam logic [4:0] OP_SLT = 5'd9;
    localparam logic [4:0] OP_LUI = 5'd10;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef struct packed {
        logic [31:0] value;
        logic        ovf;
        logic        ill;
    } alu_res_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [4:0]  op;
    alu_res_t    calc;
    logic [31:0] shifted;

    function automatic logic is_shift(input logic [4:0] code);
        return (code == OP_SLL) || (code == OP_SRL) || (code == OP_SRA);
    endfunction

    // Shift ops only reach this path with a zero amount, so they pass B through.
    function automatic alu_res_t alu_calc(input logic        sgn,
                                          input logic [4:0]  code,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        alu_res_t           r;
        logic [31:0]        sum;
        logic [31:0]        diff;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sum     = a + b;
        diff    = a - b;
        sa      = a;
        sb      = b;
        r.value = '0;
        r.ovf   = 1'b0;
        r.ill   = 1'b0;
        case (code)
            OP_ADD: begin
                r.value = sum;
                r.ovf   = sgn & (a[31] == b[31]) & (sum[31] != a[31]);
            end
            OP_SUB: begin
                r.value = diff;
                r.ovf   = sgn & (a[31] != b[31]) & (diff[31] != a[31]);
            end
            OP_AND:  r.value = a & b;
            OP_OR:   r.value = a | b;
            OP_XOR:  r.value = a ^ b;
            OP_NOR:  r.value = ~(a | b);
            OP_SLL,
            OP_SRL,
            OP_SRA:  r.value = b;
            OP_SLT:  r.value = {31'd0, sgn ? (sa < sb) : (a < b)};
            OP_LUI:  r.value = {b[15:0], 16'h0000};
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] shift_one(input logic [4:0] code, input logic [31:0] v);
        case (code)
            OP_SLL:  return {v[30:0], 1'b0};
            OP_SRL:  return {1'b0, v[31:1]};
            default: return {v[31], v[31:1]};
        endcase
    endfunction

    always_comb begin
        calc    = alu_calc(Sign, ALUCtrl, A, B);
        shifted = shift_one(op, result);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op        <= '0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        op       <= ALUCtrl;
                        if (is_shift(ALUCtrl) && (A[4:0] != 5'd0)) begin
                            result   <= B;
                            cnt      <= A[4:0];
                            zero     <= 1'b0;
                            overflow <= 1'b0;
                            illegal  <= 1'b0;
                            state    <= SHIFT;
                        end else begin
                            result    <= calc.value;
                            zero      <= (calc.value == 32'd0);
                            overflow  <= calc.ovf;
                            illegal   <= calc.ill;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    result <= shifted;
                    cnt    <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        zero      <= (shifted == 32'd0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Result and flags are held untouched until the consumer takes them.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed scenarios plus random operations against an arithmetic
// reference model of the operation table, latency and handshake rules.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        Sign;
    logic [4:0]  ALUCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_exec_unit dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .Sign(Sign),
        .ALUCtrl(ALUCtrl),
        .A(A),
        .B(B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .zero(zero),
        .overflow(overflow),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: true-integer arithmetic; overflow means the wrapped result differs from the exact value.
    function automatic void model(input logic s, input logic [4:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic ov, output logic il, output int lat);
        longint sa, sb, exact;
        int     amt;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        amt = int'(a[4:0]);
        r = 32'd0; ov = 1'b0; il = 1'b0; exact = 0;
        case (op)
            5'd0: begin r = a + b; exact = sa + sb; ov = s && (exact != longint'($signed(r))); end
            5'd1: begin r = a - b; exact = sa - sb; ov = s && (exact != longint'($signed(r))); end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a ^ b;
            5'd5: r = ~(a | b);
            5'd6: r = b << amt;
            5'd7: r = b >> amt;
            5'd8: r = $signed(b) >>> amt;
            5'd9: r = s ? 32'(sa < sb) : 32'(a < b);
            5'd10: r = b * 32'd65536;
            default: il = 1'b1;
        endcase
        lat = (op >= 5'd6 && op <= 5'd8 && amt > 0) ? amt + 1 : 1;
    endfunction

    task automatic do_op(input logic s, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string tag, output logic [31:0] got_res);
        logic [31:0] er;
        logic        eo, ei;
        int          elat, lat, waited;
        bit          seen, busy_ok;
        model(s, op, a, b, er, eo, ei, elat);
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check({tag, ".ready"}, {31'd0, in_ready}, 32'd1);
        Sign = s; ALUCtrl = op; A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        Sign = 1'($urandom); ALUCtrl = 5'($urandom); A = $urandom; B = $urandom;
        lat = 1; seen = 0; busy_ok = 1;
        while (lat <= 40) begin
            if (out_valid) begin
                seen = 1;
                break;
            end
            if (in_ready) busy_ok = 0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".seen"}, {31'd0, seen}, 32'd1);
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        check({tag, ".busy"}, {31'd0, busy_ok & ~in_ready}, 32'd1);
        check({tag, ".result"}, result, er);
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, er == 32'd0});
        check({tag, ".ovf"}, {31'd0, overflow}, {31'd0, eo});
        check({tag, ".illegal"}, {31'd0, illegal}, {31'd0, ei});
        got_res = result;
        if (out_ready) begin
            @(posedge clk); #1;
            check({tag, ".release"}, {30'd0, in_ready, out_valid}, 32'd2);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic        s;
        logic [4:0]  op;
        logic [31:0] a, b;
        bit          seen;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        Sign = 1'b0; ALUCtrl = 5'd0; A = 32'd0; B = 32'd0;
        #3;
        check("reset.result", result, 32'd0);
        check("reset.flags", {28'd0, zero, overflow, illegal, out_valid}, 32'd0);
        check("reset.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(1'b1, 5'd0, 32'h7FFFFFFF, 32'd1, "add_s", r);
        check("add_s.lit", {r[31:1], overflow}, {31'h40000000, 1'b1});
        do_op(1'b0, 5'd0, 32'h7FFFFFFF, 32'd1, "add_u", r);
        check("add_u.lit", r, 32'h80000000);
        do_op(1'b0, 5'd6, 32'd5, 32'h00000003, "sll5", r);
        check("sll5.lit", r, 32'h00000060);
        do_op(1'b0, 5'd8, 32'd31, 32'h80000000, "sra31", r);
        check("sra31.lit", r, 32'hFFFFFFFF);
        do_op(1'b0, 5'd7, 32'd0, 32'hDEADBEEF, "srl0", r);
        check("srl0.lit", r, 32'hDEADBEEF);
        do_op(1'b1, 5'd9, 32'hFFFFFFFF, 32'd1, "slt_s", r);
        check("slt_s.lit", r, 32'd1);
        do_op(1'b0, 5'd9, 32'hFFFFFFFF, 32'd1, "slt_u", r);
        check("slt_u.lit", r, 32'd0);
        do_op(1'b0, 5'd10, 32'h0, 32'h0000ABCD, "lui", r);
        check("lui.lit", r, 32'hABCD0000);
        do_op(1'b1, 5'd17, 32'h1234, 32'h5678, "undef", r);
        check("undef.lit", {r[30:0], zero, illegal}, 33'h3);

        // Backpressure: result held while a new request is offered and must be ignored.
        out_ready = 1'b0;
        do_op(1'b0, 5'd1, 32'h12345678, 32'h12345678, "bp_sub", r);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; ALUCtrl = 5'd0; A = 32'd1; B = 32'd1;
            @(posedge clk); #1;
            check("bp.hold", {result[29:0], zero, out_valid}, 32'h3);
            check("bp.in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.release", {30'd0, in_ready, out_valid}, 32'd2);

        // Reset in the middle of a 20-bit srl: no response may ever appear.
        Sign = 1'b0; ALUCtrl = 5'd7; A = 32'd20; B = 32'hF0F0F0F0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid.result", result, 32'd0);
        check("rst_mid.flags", {28'd0, zero, overflow, illegal, out_valid}, 32'd0);
        check("rst_mid.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid.ready_after", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        check("rst_mid.no_valid", {31'd0, seen}, 32'd0);
        do_op(1'b1, 5'd0, 32'd2, 32'd3, "post_rst_add", r);
        check("post_rst_add.lit", r, 32'd5);

        for (int i = 0; i < 40; i++) begin
            s  = 1'($urandom);
            op = 5'($urandom_range(0, 12));
            a  = $urandom;
            b  = $urandom;
            if (i % 4 == 0) b = a ^ 32'h80000000;
            if (i % 7 == 0) b = a;
            do_op(s, op, a, b, "rand", r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execution unit that consumes the `{Sign, ALUCtrl}` control word emitted by the ALU controller and performs the selected 32-bit operation. Operands and the control word arrive on a valid/ready request channel, and results leave on a valid/ready response channel. Shifts run iteratively, one bit per cycle; all other operations complete in one cycle. The unit sits between the decode/operand-fetch stage and the writeback stage of the processor datapath.

## Interface
- Parameters: none. The datapath is fixed at 32 bits.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- Sign  in  1  1 = signed arithmetic/compare, 0 = unsigned
- ALUCtrl  in  5  operation code (see Operation)
- A  in  32  operand A; A[4:0] is the shift amount for shifts
- B  in  32  operand B; this is the value shifted for shifts and lui
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- result  out  32  registered result
- zero  out  1  result == 0
- overflow  out  1  signed add/sub overflow
- illegal  out  1  ALUCtrl code is undefined

## Operation
- ALUCtrl codes:
  - 0 add (A+B)
  - 1 sub (A−B)
  - 2 and
  - 3 or
  - 4 xor
  - 5 nor
  - 6 sll (B<<A[4:0])
  - 7 srl
  - 8 sra
  - 9 slt
  - 10 lui ({B[15:0],16'h0})
  - 11–31 undefined
- Arithmetic: add/sub wrap modulo 2^32.
- overflow:
  - Set only when Sign=1 and the operation is add/sub.
  - add: operand signs equal and result sign differs.
  - sub: operand signs differ and result sign differs from A.
  - Always 0 otherwise.
- slt: result = 32'd1 or 32'd0. Sign=1 compares A<B as two's complement; Sign=0 compares unsigned.
- sra is arithmetic regardless of Sign. srl fills with zeros.
- Undefined codes: result=0, zero=1, illegal=1, overflow=0.
- zero is computed from the final result and is registered together with it.
- FSM states:
  - IDLE
    - in_ready=1, out_valid=0.
    - On in_valid: latch Sign, ALUCtrl, A, B.
    - Non-shift op, or shift with A[4:0]=0: compute, register outputs, go to DONE.
    - Shift with A[4:0]>0: result←B, cnt←A[4:0], go to SHIFT.
  - SHIFT
    - in_ready=0, out_valid=0.
    - Each cycle: result shifts by 1 per the op, cnt←cnt−1.
    - On the cycle cnt==1: apply the final shift, update zero, go to DONE.
  - DONE
    - in_ready=0, out_valid=1.
    - result and flags hold stable.
    - On out_ready: go to IDLE.
- A single request is outstanding at a time. There is no acceptance in SHIFT or DONE.
- Operand, control and shift-amount inputs are ignored while in_ready=0.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE, cnt = 0.
  - result = 0, zero = 0, overflow = 0, illegal = 0, out_valid = 0, in_ready = 1.
- Reset mid-operation: the in-flight request is discarded with no output. The unit is ready on the first cycle after reset deasserts.
- Accept edge E0 occurs when in_valid && in_ready.
  - Non-shift op: out_valid=1 in the cycle after E0.
  - Shift by n>0: out_valid=1 in cycle n+1 after E0, with n SHIFT cycles in between.
  - Shift by 0: behaves as non-shift, result = B.
- Response edge: out_valid && out_ready returns the FSM to IDLE. in_ready=1 in the following cycle.
- Minimum request spacing is 2 cycles (non-shift, out_ready held high). The worst case is 33 cycles (shift by 31).
- out_valid, once asserted, stays high with result and flags unchanged until accepted.
- in_ready and out_valid are never simultaneously high.

## Test plan
- Reset then add: Sign=1, ALUCtrl=0, A=32'h7FFFFFFF, B=1 → next cycle out_valid=1, result=32'h80000000, overflow=1, zero=0. The same inputs with Sign=0 give overflow=0.
- Shift latency: sll with A=5, B=32'h00000003 → out_valid rises exactly 6 cycles after acceptance, result=32'h00000060, in_ready=0 throughout. sra with A=31, B=32'h80000000 → result=32'hFFFFFFFF after 32 cycles.
- Backpressure: sub with A=B=32'h12345678 and out_ready=0 for 10 cycles → result=0, zero=1 held stable, in_ready=0, a new in_valid is ignored. Asserting out_ready gives in_ready=1 in the next cycle.
- Compare sign: A=32'hFFFFFFFF, B=1, ALUCtrl=9 → Sign=1 gives result=1; Sign=0 gives result=0. lui with B=32'h0000ABCD → 32'hABCD0000.
- Undefined code: ALUCtrl=17 → result=0, zero=1, illegal=1, single-cycle latency.
- Reset mid-shift: srl with A=20; assert reset after 5 shift cycles → all outputs return to reset values immediately, no out_valid pulse. A new add (A=2, B=3) then returns 5.
